// File: rtl/spi_adc128s022.sv
// SPI master for the ADC128S022: one 16-SCLK frame per accepted start,
// address shifted out on DIN, 12-bit result captured from DOUT.
module spi_adc128s022 #(
    parameter int HALF_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  channel,
    output logic        SCLK,
    output logic        DIN,
    output logic        CS_N,
    input  logic        DOUT,
    output logic        done,
    output logic [11:0] data
);
    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HALF_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   ctrl_q, ctrl_d;
    logic [15:0]   shreg_q, shreg_d;
    logic          sclk_q, sclk_d;
    logic          din_q, din_d;
    logic          cs_n_q, cs_n_d;
    logic          done_q, done_d;
    logic [11:0]   data_q, data_d;

    logic phase_end, accept;
    assign phase_end = (cnt_q == CNT_MAX);
    // The done cycle is already IDLE, so a start there must be masked.
    assign accept    = start && !done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            ctrl_q    <= '0;
            shreg_q   <= '0;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            ctrl_q    <= ctrl_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (phase_end) state_d = SHIFT;
            SHIFT:   if (phase_end && !sclk_q && bit_cnt_q == 5'd16) state_d = HOLD;
            HOLD:    if (phase_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        ctrl_d    = ctrl_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;
        data_d    = data_q;
        if (state_q == IDLE) begin
            cnt_d  = '0;
            sclk_d = 1'b1;
            din_d  = 1'b0;
            cs_n_d = 1'b1;
            if (accept) begin
                ctrl_d    = {2'b00, channel, 11'b0};
                bit_cnt_d = '0;
                shreg_d   = '0;
                cs_n_d    = 1'b0;
            end
        end else begin
            cnt_d = phase_end ? '0 : cnt_q + 1'b1;
            if (phase_end) begin
                if (state_q == HOLD) begin
                    cs_n_d = 1'b1;
                    din_d  = 1'b0;
                    data_d = shreg_q[11:0];
                    done_d = 1'b1;
                end else if (sclk_q) begin
                    // Falling edge: SETUP's end issues edge 1, SHIFT issues 2..16.
                    sclk_d    = 1'b0;
                    din_d     = ctrl_q[15];
                    ctrl_d    = {ctrl_q[14:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end else begin
                    sclk_d  = 1'b1;
                    shreg_d = {shreg_q[14:0], DOUT};
                end
            end
        end
    end

    assign SCLK = sclk_q;
    assign DIN  = din_q;
    assign CS_N = cs_n_q;
    assign done = done_q;
    assign data = data_q;
endmodule

// File: tb/tb_spi_adc128s022.sv
// Bench for spi_adc128s022: ADC pin model plus frame-level reference checks.
module tb_spi_adc128s022;
    localparam int H = 13;
    localparam int DONE_LAT = 1 + 33 * H;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, DOUT = 1'b0;
    logic [2:0]  channel = 3'd0;
    logic        SCLK, DIN, CS_N, done;
    logic [11:0] data;

    spi_adc128s022 #(.HALF_DIV(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .channel(channel),
        .SCLK(SCLK), .DIN(DIN), .CS_N(CS_N), .DOUT(DOUT),
        .done(done), .data(data)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC pin model and bus monitor
    logic [15:0] adc_word = 16'h0, din_frame = 16'h0;
    logic [11:0] prev_data = 12'h0, done_data = 12'h0;
    logic        prev_sclk = 1'b1;
    int falls = 0, rises = 0, last_edge = 0, fall1_cyc = 0, bad_phase = 0;
    int done_cnt = 0, done_total = 0, done_cyc = 0, idle_tog = 0, data_bad = 0, cs_low = 0;

    always @(negedge clk) begin
        if (CS_N === 1'b0) cs_low++;
        if (CS_N === 1'b0 && prev_sclk && !SCLK) begin
            falls++;
            if (falls == 1) fall1_cyc = cyc;
            else if (cyc - last_edge != H) bad_phase++;
            last_edge = cyc;
            if (falls <= 16) begin
                din_frame[16-falls] = DIN;
                DOUT = adc_word[16-falls];
            end
        end
        if (CS_N === 1'b0 && !prev_sclk && SCLK) begin
            rises++;
            if (cyc - last_edge != H) bad_phase++;
            last_edge = cyc;
        end
        if (CS_N === 1'b1 && SCLK !== prev_sclk) idle_tog++;
        if (done === 1'b1) begin
            done_cnt++;
            done_total++;
            done_cyc  = cyc;
            done_data = data;
        end
        if (data !== prev_data && done !== 1'b1) data_bad++;
        prev_data = data;
        prev_sclk = SCLK;
    end

    int t0 = 0;
    task automatic start_frame(input logic [2:0] ch, input logic [15:0] word);
        @(negedge clk);
        #1;
        adc_word  = word;
        falls     = 0;
        rises     = 0;
        done_cnt  = 0;
        bad_phase = 0;
        din_frame = 16'h0;
        channel   = ch;
        start     = 1'b1;
        t0        = cyc;
        @(negedge clk);
        #1;
        start   = 1'b0;
        channel = 3'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 * H && done_cnt == 0; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < 40 * H && rises < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rise_wait", 32'(rises >= n), 32'd1);
    endtask

    // Expected control word: two zeros, then the 3 address bits, then zeros.
    task automatic check_frame(input logic [2:0] ch, input logic [15:0] word);
        logic [15:0] exp_din;
        exp_din = 16'h0;
        for (int i = 0; i < 3; i++) exp_din[13-i] = ch[2-i];
        wait_done();
        repeat (9) @(negedge clk);
        #1;
        chk("done_cnt",   32'(done_cnt), 32'd1);
        chk("done_time",  32'(done_cyc - t0), 32'(DONE_LAT));
        chk("data",       32'(done_data), 32'(word % 4096));
        chk("data_hold",  32'(data), 32'(word % 4096));
        chk("falls",      32'(falls), 32'd16);
        chk("rises",      32'(rises), 32'd16);
        chk("fall1_time", 32'(fall1_cyc - t0), 32'(1 + H));
        chk("din_frame",  32'(din_frame), 32'(exp_din));
        chk("phase",      32'(bad_phase), 32'd0);
        chk("cs_idle",    32'(CS_N), 32'd1);
    endtask

    task automatic run_frame(input logic [2:0] ch, input logic [15:0] word);
        start_frame(ch, word);
        check_frame(ch, word);
    endtask

    int sine_tab[4095];
    int done_before;
    real v;
    logic [15:0] w;

    initial begin
        for (int i = 0; i < 4095; i++) begin
            v = 2047.5 + 2047.0 * $sin(2.0 * 3.14159265358979 * i / 4095.0);
            sine_tab[i] = int'(v) % 4096;
        end

        // reset state and quiet idle
        repeat (5) @(negedge clk);
        #1;
        chk("rst_cs",   32'(CS_N), 32'd1);
        chk("rst_sclk", 32'(SCLK), 32'd1);
        chk("rst_din",  32'(DIN), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        rst_n    = 1'b1;
        cs_low   = 0;
        idle_tog = 0;
        repeat (100) @(negedge clk);
        #1;
        chk("idle_cs",  32'(cs_low), 32'd0);
        chk("idle_tog", 32'(idle_tog), 32'd0);

        // directed frames
        run_frame(3'd3, 16'h0ABC);
        run_frame(3'd7, 16'hF123);
        run_frame(3'd0, 16'h5FFF);

        // start and channel change mid-frame must be ignored
        start_frame(3'd5, 16'h0765);
        wait_rises(5);
        start   = 1'b1;
        channel = 3'd2;
        @(negedge clk);
        #1;
        start = 1'b0;
        check_frame(3'd5, 16'h0765);
        run_frame(3'd6, 16'h0321);

        // start presented in the done cycle is ignored
        start_frame(3'd4, 16'h0F0F);
        for (int i = 0; i < 40 * H && done !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_seen", 32'(done), 32'd1);
        start  = 1'b1;
        cs_low = 0;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("done_cyc_start", 32'(cs_low), 32'd0);
        chk("done_cyc_data",  32'(data), 32'h0F0F);

        // reset mid-frame
        start_frame(3'd1, 16'h0AAA);
        wait_rises(8);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_cs",   32'(CS_N), 32'd1);
        chk("mid_rst_sclk", 32'(SCLK), 32'd1);
        chk("mid_rst_din",  32'(DIN), 32'd0);
        chk("mid_rst_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("mid_rst_done", 32'(done_cnt), 32'd0);
        data_bad = 0;
        idle_tog = 0;
        run_frame(3'd2, 16'h0456);

        // randomized frames
        for (int i = 0; i < 8; i++) run_frame(3'($urandom), 16'($urandom));

        // streaming sine samples on channel 3, random leading nibble
        done_before = done_total;
        for (int i = 0; i < 40; i++) begin
            w = {4'($urandom), 12'(sine_tab[(i * 103) % 4095])};
            run_frame(3'd3, w);
        end
        chk("stream_dones", 32'(done_total - done_before), 32'd40);
        chk("data_only_on_done", 32'(data_bad), 32'd0);
        chk("idle_sclk_tog",     32'(idle_tog), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
